// File: rtl/sam_stream_mem.sv
// SAM stream core: decodes instruction words, performs single-word writes and streams
// multi-word read bursts (with wrap-around) through a 2-entry skid buffer.
module sam_stream_mem #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned IN_W   = 32,
  parameter int unsigned OUT_W  = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             err_op
);

  localparam int unsigned Depth = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PtrOne = ADDR_W'(1);
  localparam logic [ADDR_W:0]   RemOne = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {StIdle, StBurst, StDrain} state_e;

  state_e state_q, state_d;

  logic [DATA_W-1:0] mem [Depth];

  logic [1:0]        op;
  logic              accept, wr_en, rd_issue, pop;
  logic [ADDR_W-1:0] wr_addr, rd_start, rd_end, rd_span;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   remain_q, remain_d;
  logic              rd_vld_q, rd_last_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [1:0]        fill_q, fill_d;
  logic [DATA_W-1:0] buf0_data_q, buf0_data_d, buf1_data_q, buf1_data_d;
  logic              buf0_last_q, buf0_last_d, buf1_last_q, buf1_last_d;
  logic              err_q, err_d;
  logic              unused_in;

  assign unused_in = in_last;

  assign op       = in_data[IN_W-1 -: 2];
  assign wr_addr  = in_data[ADDR_W+DATA_W-1:DATA_W];
  assign rd_start = in_data[2*ADDR_W-1:ADDR_W];
  assign rd_end   = in_data[ADDR_W-1:0];
  assign rd_span  = rd_end - rd_start;

  assign in_ready = rstn & (state_q == StIdle);
  assign accept   = in_valid & in_ready;
  assign wr_en    = accept & (op == 2'b01);
  assign pop      = out_valid & out_ready;

  // A read is issued only if its data is guaranteed a buffer slot, even if the
  // downstream stalls in the cycle the data arrives.
  assign rd_issue = (state_q == StBurst) & (fill_d <= 2'd1);

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    remain_d = remain_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (op == 2'b10) begin
            rd_ptr_d = rd_start;
            remain_d = {1'b0, rd_span} + RemOne;
            state_d  = StBurst;
          end else if (op == 2'b11) begin
            err_d = 1'b1;
          end
        end
      end
      StBurst: begin
        if (rd_issue) begin
          rd_ptr_d = rd_ptr_q + PtrOne;
          remain_d = remain_q - RemOne;
          if (remain_q == RemOne) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (pop && out_last) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Skid buffer: pop the head first, then append the RAM result behind what remains.
  always_comb begin
    fill_d      = fill_q;
    buf0_data_d = buf0_data_q;
    buf0_last_d = buf0_last_q;
    buf1_data_d = buf1_data_q;
    buf1_last_d = buf1_last_q;
    if (pop) begin
      buf0_data_d = buf1_data_q;
      buf0_last_d = buf1_last_q;
      fill_d      = fill_q - 2'd1;
    end
    if (rd_vld_q) begin
      if (fill_d == 2'd0) begin
        buf0_data_d = rd_data_q;
        buf0_last_d = rd_last_q;
      end else begin
        buf1_data_d = rd_data_q;
        buf1_last_d = rd_last_q;
      end
      fill_d = fill_d + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= in_data[DATA_W-1:0];
    end
    if (rd_issue) begin
      rd_data_q <= mem[rd_ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= StIdle;
      rd_ptr_q    <= '0;
      remain_q    <= '0;
      rd_vld_q    <= 1'b0;
      rd_last_q   <= 1'b0;
      fill_q      <= 2'd0;
      buf0_data_q <= '0;
      buf0_last_q <= 1'b0;
      buf1_data_q <= '0;
      buf1_last_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      remain_q    <= remain_d;
      rd_vld_q    <= rd_issue;
      rd_last_q   <= rd_issue & (remain_q == RemOne);
      fill_q      <= fill_d;
      buf0_data_q <= buf0_data_d;
      buf0_last_q <= buf0_last_d;
      buf1_data_q <= buf1_data_d;
      buf1_last_q <= buf1_last_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = (fill_q != 2'd0);
  assign out_last  = out_valid & buf0_last_q;
  assign out_data  = OUT_W'(buf0_data_q);
  assign err_op    = err_q;

endmodule
